// File: rtl/icache_refill_pkg.sv
// Shared AXI read-channel constants, refill FSM state encoding and burst geometry helpers.
package icache_refill_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_RESP_SLV   = 2'b10;
    localparam logic [1:0] AXI_RESP_DEC   = 2'b11;

    function automatic int unsigned refill_beats(int unsigned line_bytes, int unsigned data_w);
        return (line_bytes * 8) / data_w;
    endfunction

    function automatic logic axi_resp_is_err(logic [1:0] resp);
        return (resp == AXI_RESP_SLV) || (resp == AXI_RESP_DEC);
    endfunction

endpackage

// File: rtl/icache_refill.sv
// Instruction-cache line refill engine: one INCR AXI read burst per miss, line assembled in flops.
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int unsigned AXI_ADDR_W = 64,
    parameter int unsigned AXI_ID_W   = 8,
    parameter int unsigned AXI_DATA_W = 64,
    parameter int unsigned LINE_BYTES = 32,
    parameter int unsigned REFILL_ID  = 0
) (
    input  logic                    aclk,
    input  logic                    arst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [AXI_ADDR_W-1:0]   req_addr,
    input  logic                    flush,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [AXI_ADDR_W-1:0]   resp_addr,
    output logic [LINE_BYTES*8-1:0] resp_data,
    output logic                    resp_err,
    output logic                    mst_arvalid,
    input  logic                    mst_arready,
    output logic [AXI_ADDR_W-1:0]   mst_araddr,
    output logic [7:0]              mst_arlen,
    output logic [2:0]              mst_arsize,
    output logic [1:0]              mst_arburst,
    output logic [AXI_ID_W-1:0]     mst_arid,
    output logic                    mst_arlock,
    output logic [3:0]              mst_arcache,
    output logic [2:0]              mst_arprot,
    output logic [3:0]              mst_arqos,
    output logic [3:0]              mst_arregion,
    input  logic                    mst_rvalid,
    output logic                    mst_rready,
    input  logic [AXI_ID_W-1:0]     mst_rid,
    input  logic [1:0]              mst_rresp,
    input  logic [AXI_DATA_W-1:0]   mst_rdata,
    input  logic                    mst_rlast
);

    localparam int unsigned BEATS = refill_beats(LINE_BYTES, AXI_DATA_W);
    localparam int unsigned CNT_W = $clog2(BEATS) + 1;
    localparam logic [AXI_ADDR_W-1:0] LINE_MASK = AXI_ADDR_W'(LINE_BYTES - 1);
    localparam logic [AXI_ID_W-1:0]   RID       = AXI_ID_W'(REFILL_ID);
    localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(BEATS - 1);

    state_e                          state_q, state_d;
    logic [AXI_ADDR_W-1:0]           addr_q, addr_d;
    logic [BEATS-1:0][AXI_DATA_W-1:0] line_q, line_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            err_q, err_d;
    logic                            discard_q, discard_d;
    logic                            final_beat;
    logic                            beat_err;
    logic                            drop_line;

    assign final_beat = (cnt_q == LAST_CNT);
    // rlast must coincide exactly with the final counted beat; either mismatch poisons the line
    assign beat_err   = axi_resp_is_err(mst_rresp) | (mst_rid != RID) | (mst_rlast != final_beat);
    assign drop_line  = discard_q | flush;

    assign mst_araddr   = addr_q;
    assign mst_arlen    = 8'(BEATS - 1);
    assign mst_arsize   = 3'($clog2(AXI_DATA_W / 8));
    assign mst_arburst  = AXI_BURST_INCR;
    assign mst_arid     = RID;
    assign mst_arlock   = 1'b0;
    assign mst_arcache  = 4'd0;
    assign mst_arprot   = 3'd0;
    assign mst_arqos    = 4'd0;
    assign mst_arregion = 4'd0;
    assign resp_addr    = addr_q;
    assign resp_data    = line_q;

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            discard_q <= discard_d;
        end
    end

    always_ff @(posedge aclk) begin
        addr_q <= addr_d;
        line_q <= line_d;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        line_d      = line_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        discard_d   = discard_q;
        req_ready   = 1'b0;
        mst_arvalid = 1'b0;
        mst_rready  = 1'b0;
        resp_valid  = 1'b0;
        resp_err    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d    = req_addr & ~LINE_MASK;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    discard_d = 1'b0;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                mst_arvalid = 1'b1;
                if (flush) discard_d = 1'b1;
                if (mst_arready) state_d = ST_DATA;
            end
            ST_DATA: begin
                mst_rready = 1'b1;
                if (flush) discard_d = 1'b1;
                if (mst_rvalid) begin
                    for (int i = 0; i < int'(BEATS); i++) begin
                        if (cnt_q == CNT_W'(i)) line_d[i] = mst_rdata;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (beat_err) err_d = 1'b1;
                    if (final_beat && !mst_rlast) begin
                        state_d = ST_DRAIN;
                    end else if (final_beat || mst_rlast) begin
                        state_d = drop_line ? ST_IDLE : ST_RESP;
                    end
                end
            end
            ST_DRAIN: begin
                // surplus beats are accepted and thrown away until the slave closes the burst
                mst_rready = 1'b1;
                if (flush) discard_d = 1'b1;
                if (mst_rvalid && mst_rlast) state_d = drop_line ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: doc/icache_refill.md
ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 Parameter AXI_ADDR_W, default 64, AXI address width.
REQ-002 Parameter AXI_ID_W, default 8, AXI ID width.
REQ-003 Parameter AXI_DATA_W, default 64, AXI data width (bits per beat).
REQ-004 Parameter LINE_BYTES, default 32, cache line size; power of two, multiple of AXI_DATA_W/8.
REQ-005 Parameter REFILL_ID, default 0, constant value driven on mst_arid.
REQ-006 Ports (name, direction, width, meaning):
- aclk, in, 1, sole clock.
- arst, in, 1, asynchronous active-high reset.
- req_valid, in, 1, refill request valid.
- req_ready, out, 1, refill request accepted.
- req_addr, in, AXI_ADDR_W, miss address.
- flush, in, 1, discard the refill in flight.
- resp_valid, out, 1, line available.
- resp_ready, in, 1, line consumed.
- resp_addr, out, AXI_ADDR_W, line-aligned address.
- resp_data, out, LINE_BYTES*8, line data, beat 0 in the LSBs.
- resp_err, out, 1, refill failed.
- mst_arvalid, out, 1, AXI read address valid.
- mst_arready, in, 1, AXI read address ready.
- mst_araddr, out, AXI_ADDR_W, AXI read address.
- mst_arlen, out, 8, AXI burst length.
- mst_arsize, out, 3, AXI beat size.
- mst_arburst, out, 2, AXI burst type.
- mst_arid, out, AXI_ID_W, AXI read ID.
- mst_arlock, out, 1, AXI lock; constant 0.
- mst_arcache, out, 4, AXI cache attributes; constant 0.
- mst_arprot, out, 3, AXI protection; constant 0.
- mst_arqos, out, 4, AXI QoS; constant 0.
- mst_arregion, out, 4, AXI region; constant 0.
- mst_rvalid, in, 1, AXI read data valid.
- mst_rready, out, 1, AXI read data ready.
- mst_rid, in, AXI_ID_W, AXI read ID.
- mst_rresp, in, 2, AXI read response.
- mst_rdata, in, AXI_DATA_W, AXI read data.
- mst_rlast, in, 1, AXI last beat.
REQ-007 The block SHALL use one clock, aclk; reset arst SHALL be asynchronous and active-high.

Function
REQ-008 The block SHALL implement states IDLE, ADDR, DATA, RESP, DRAIN.
REQ-009 In IDLE, req_ready SHALL be 1; all other states SHALL drive req_ready 0.
REQ-010 In IDLE, req_valid&req_ready SHALL latch req_addr with the low log2(LINE_BYTES) bits cleared, clear the beat counter and error flag, and move to ADDR.
REQ-011 In ADDR, mst_arvalid SHALL be 1 with araddr = latched line address, arlen = BEATS-1, arsize = log2(AXI_DATA_W/8), arburst = 2'b01 (INCR), arid = REFILL_ID; all AR fields SHALL be stable until mst_arready; the AR handshake SHALL move the FSM to DATA.
REQ-012 In DATA, mst_rready SHALL be 1; each R handshake SHALL write mst_rdata into line slot [beat counter] and increment the counter.
REQ-013 The error flag SHALL be set (sticky) on any beat with mst_rresp[1]=1, mst_rid≠REFILL_ID, mst_rlast=1 before the final beat, or mst_rlast=0 on the final beat.
REQ-014 The FSM SHALL leave DATA on the handshake of the final beat (counter==BEATS-1) or of any beat with mst_rlast=1, whichever comes first.
REQ-015 The FSM SHALL then go to RESP if no flush is pending; in RESP, resp_valid=1 and resp_err=error flag, and resp_addr and resp_data SHALL be held until resp_ready, after which the FSM returns to IDLE.
REQ-016 flush asserted in ADDR or DATA SHALL set a pending-discard flag; the AXI transaction SHALL still complete, and the FSM SHALL then go to IDLE without asserting resp_valid.
REQ-017 flush in IDLE or RESP SHALL have no effect; flush in the same cycle as a request acceptance SHALL NOT cancel that request.
REQ-018 If the slave returns mst_rlast=0 on the final counted beat, the FSM SHALL enter DRAIN and keep mst_rready=1 until an rlast handshake, then proceed as in REQ-015/REQ-016.
REQ-019 Beat counter width SHALL be log2(BEATS)+1, where BEATS = LINE_BYTES*8/AXI_DATA_W; the counter SHALL NOT wrap within a burst.
REQ-020 Response latency SHALL be: first resp_valid cycle ≥ 2 + BEATS cycles after request acceptance with zero-wait AXI.

Reset
REQ-021 On arst, the block SHALL reset: state=IDLE, mst_arvalid=0, mst_rready=0, resp_valid=0, resp_err=0, counter=0, error and discard flags=0.
REQ-022 Line buffer and latched address SHALL NOT require reset.
REQ-023 Reset mid-burst SHALL abandon the transaction immediately; interconnect reset is assumed simultaneous.

Structure
REQ-024 State encodings, the AXI burst/resp constants (INCR=2'b01, SLVERR/DECERR) and the BEATS derivation SHALL reside in the shared AXI package.
REQ-025 The block SHALL be a single module without sub-modules; the line buffer SHALL be flops.

Verification
REQ-026 Request 0x8000_0014 against a zero-wait slave -> araddr 0x8000_0000, arlen 3, arsize 3, arburst 1; resp_data = 4 beats in order; resp_err 0.
REQ-027 rresp=2'b10 on beat 2 -> all 4 beats accepted, resp_err 1, data still assembled.
REQ-028 flush pulsed one cycle after AR handshake -> 4 beats drained, no resp_valid, req_ready 1 afterward.
REQ-029 rlast asserted on beat 1 -> DATA exits after 2 beats, resp_err 1; slave with rlast absent on beat 3 -> DRAIN until rlast, resp_err 1.
REQ-030 arready held low 10 cycles and resp_ready low 5 cycles -> AR and resp fields stable throughout; arst asserted mid-DATA -> all outputs take reset values the same cycle.
